rstn_seq: RTL

Parametrised reset controller that merges several asynchronous, active-low reset requests and a software reset pulse into one reset event. It holds all downstream resets asserted for a minimum time, then releases NUM_OUT active-low output resets in a fixed order with a programmable gap between them. It sits at the root of each clock domain's reset tree. It extends the plain two-flop reset synchroniser with a configurable synchroniser depth, source masking, reset stretching, sequenced release and a record of which source caused the reset.

---
 rtl/rstn_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rstn_seq.sv
// Reset controller: synchronises and merges reset requests, stretches the reset,
// then releases NUM_OUT active-low resets in order and records the reset cause.
module rstn_seq #(
  parameter int NUM_SRC     = 4,
  parameter int NUM_OUT     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] rstn_src,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               sw_rst_req,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] rstn_out,
  output logic               rst_done,
  output logic [NUM_SRC:0]   rst_cause
);

  localparam int CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {HOLD, SEQ, RUN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_OUT-1:0]   out_d;
  logic                 done_d;
  logic [NUM_SRC:0]     cause_d;

  logic [SYNC_STAGES-1:0] sync_q [NUM_SRC];
  logic [NUM_SRC-1:0]     sync_out;
  logic [NUM_SRC-1:0]     src_req;
  logic                   req_any;

  // Chains clear to 0 so every source looks asserted straight out of reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst) sync_q[i] <= '0;
      else     sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], rstn_src[i]};
    end
  end

  always_comb begin
    sync_out = '0;
    for (int i = 0; i < NUM_SRC; i++) sync_out[i] = sync_q[i][SYNC_STAGES-1];
  end

  assign src_req = ~sync_out & src_mask;
  assign req_any = (|src_req) | sw_rst_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = rstn_out;
    done_d  = rst_done;
    cause_d = rst_cause;

    // Clear first so a simultaneous new cause survives it
    if (cause_clr) cause_d = '0;
    if (state_q != HOLD) cause_d = cause_d | {sw_rst_req, src_req};

    case (state_q)
      HOLD: begin
        if (req_any) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d  = SEQ;
          out_d[0] = 1'b1;
          cnt_d    = '0;
          idx_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEQ: begin
        if (req_any) begin
          state_d = HOLD;
          out_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == STEP_LAST) begin
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + 1'b1;
            cnt_d = '0;
            for (int k = 0; k < NUM_OUT; k++) begin
              if (k == int'(idx_q) + 1) out_d[k] = 1'b1;
            end
          end else begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (req_any) begin
          state_d = HOLD;
          out_d   = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rstn_out  <= '0;
      rst_done  <= 1'b0;
      rst_cause <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rstn_out  <= out_d;
      rst_done  <= done_d;
      rst_cause <= cause_d;
    end
  end

endmodule
